// File: rtl/router_fifo_sched.sv
// Tile sequencer and round-robin pop arbiter for the router's multi-peek FIFO.
// Optional idle-SERVE watchdog is built when ROUTER_SCHED_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for i_start
// ST_CLEAR   | one-cycle FIFO clear at tile start
// ST_LOAD    | waiting for the single tile write
// ST_SERVE   | round-robin pop arbitration until the FIFO drains
// ST_DONE    | one-cycle tile-complete pulse
// ST_TIMEOUT | one-cycle watchdog pulse (watchdog build only)
// ST_FLUSH   | clear the stuck tile, then return to idle (watchdog build only)
module router_fifo_sched #(
    parameter int NUM_REQ        = 4,
    parameter int PEEK_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  logic                          i_start,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    output logic                          o_fifo_clear,
    output logic                          o_fifo_write_en,
    input  logic                          i_fifo_empty,
    input  logic                          i_fifo_full,
    input  logic [PEEK_WIDTH-1:0]         i_peek_valid,
    output logic                          o_fifo_pop_en,
    output logic [PEEK_WIDTH-1:0]         o_fifo_data_hit,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*PEEK_WIDTH-1:0] i_req_hit,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_SERVE,
        ST_DONE,
        ST_TIMEOUT,
        ST_FLUSH
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       win;
    logic [PTR_W-1:0]       rr_next;
    logic                   found;
    logic [NUM_REQ-1:0]     eligible;
    logic [PEEK_WIDTH-1:0]  win_hit;
    logic                   grant_fire;
    logic                   load_fire;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = i_req[k] & (|(i_req_hit[k*PEEK_WIDTH +: PEEK_WIDTH] & i_peek_valid));
        end
    end

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[(int'(rr_ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign win_hit    = i_req_hit[int'(win)*PEEK_WIDTH +: PEEK_WIDTH] & i_peek_valid;
    assign rr_next    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    assign grant_fire = i_nrst && (state == ST_SERVE) && !i_fifo_empty && found;
    assign load_fire  = i_nrst && (state == ST_LOAD) && i_data_valid && !i_fifo_full;

    // Outputs are gated by i_nrst so they read zero while reset is held.
    assign o_fifo_clear    = i_nrst && ((state == ST_CLEAR) || (state == ST_FLUSH));
    assign o_data_ready    = i_nrst && (state == ST_LOAD);
    assign o_fifo_write_en = load_fire;
    assign o_fifo_pop_en   = grant_fire;
    assign o_grant         = grant_fire ? (NUM_REQ'(1) << win) : '0;
    assign o_fifo_data_hit = grant_fire ? win_hit : '0;
    assign o_busy          = i_nrst && (state != ST_IDLE);
    assign o_done          = i_nrst && (state == ST_DONE);

`ifdef ROUTER_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_serve;

    assign idle_serve = (state == ST_SERVE) && !i_fifo_empty && !grant_fire;
    assign o_timeout  = i_nrst && (state == ST_TIMEOUT);
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign o_timeout  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
`ifdef ROUTER_SCHED_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            if (grant_fire) begin
                rr_ptr <= rr_next;
            end

`ifdef ROUTER_SCHED_TIMEOUT_EN
            if (idle_serve && (idle_cnt != CNT_LAST)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
`endif

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (i_fifo_empty) begin
                        state <= ST_DONE;
                    end
`ifdef ROUTER_SCHED_TIMEOUT_EN
                    else if (idle_serve && (idle_cnt == CNT_LAST)) begin
                        state <= ST_TIMEOUT;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_TIMEOUT: begin
                    state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
